// File: rtl/fetch_sequencer_if.sv
// Instruction-memory fetch channel: one request outstanding, req/gnt accept, rvalid response.
interface fetch_sequencer_if;
    logic        req;
    logic [31:0] addr;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;

    modport master (output req, output addr, input gnt, input rvalid, input rdata);
    modport slave  (input req, input addr, output gnt, output rvalid, output rdata);
endinterface

// File: rtl/fetch_sequencer.sv
// IF-stage controller: owns PCF, fetches over the imem channel and loads the IF/ID register,
// honouring hazard stalls and EX redirects and discarding wrong-path responses.
module fetch_sequencer #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               PCSrcE,
    input  logic [31:0]        PCTargetE,
    input  logic               StallF,
    fetch_sequencer_if.master  imem,
    output logic [31:0]        InstrD,
    output logic [31:0]        PCD,
    output logic [31:0]        PCPlus4D,
    output logic               ValidD
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {ST_ISSUE, ST_WAIT, ST_HOLD} state_e;

    state_e            state_q, state_d;
    logic [XLEN-1:0]   pcf_q, pcf_d;
    logic              kill_q, kill_d;
    logic [XLEN-1:0]   hold_q, hold_d;
    logic [XLEN-1:0]   instr_q, instr_d;
    logic [XLEN-1:0]   pcd_q, pcd_d;
    logic [XLEN-1:0]   pcp4_q, pcp4_d;
    logic              valid_q, valid_d;
    logic              load;
    logic [XLEN-1:0]   load_data;
    logic              req_c;

    // A reset that lands while a response is still owed marks it stale so it is dropped on arrival.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_ISSUE;
            pcf_q   <= RESET_PC;
            kill_q  <= ((state_q == ST_WAIT) | kill_q) & ~imem.rvalid;
            hold_q  <= '0;
            instr_q <= NOP_INSTR;
            pcd_q   <= '0;
            pcp4_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pcf_q   <= pcf_d;
            kill_q  <= kill_d;
            hold_q  <= hold_d;
            instr_q <= instr_d;
            pcd_q   <= pcd_d;
            pcp4_q  <= pcp4_d;
            valid_q <= valid_d;
        end
    end

    always_comb begin : next_state
        state_d   = state_q;
        pcf_d     = pcf_q;
        kill_d    = kill_q;
        hold_d    = hold_q;
        instr_d   = instr_q;
        pcd_d     = pcd_q;
        pcp4_d    = pcp4_q;
        valid_d   = valid_q;
        load      = 1'b0;
        load_data = hold_q;

        case (state_q)
            ST_ISSUE: begin
                if (kill_q && imem.rvalid) kill_d = 1'b0;
                if (req_c && imem.gnt)     state_d = ST_WAIT;
            end
            ST_WAIT: begin
                if (imem.rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = ST_ISSUE;
                    end else if (StallF) begin
                        hold_d  = imem.rdata;
                        state_d = ST_HOLD;
                    end else begin
                        load      = 1'b1;
                        load_data = imem.rdata;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_HOLD: begin
                if (!StallF) begin
                    load    = 1'b1;
                    state_d = ST_ISSUE;
                end
            end
            default: state_d = ST_ISSUE;
        endcase

        if (load) begin
            instr_d = load_data;
            pcd_d   = pcf_q;
            pcp4_d  = pcf_q + XLEN'(4);
            valid_d = 1'b1;
            pcf_d   = pcf_q + XLEN'(4);
        end else if (!StallF) begin
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
        end

        // Redirect overrides stalls and loads; an in-flight fetch becomes a stale response.
        if (PCSrcE) begin
            pcf_d   = PCTargetE & ~XLEN'(3);
            instr_d = NOP_INSTR;
            valid_d = 1'b0;
            case (state_q)
                ST_ISSUE: begin
                    if (req_c && imem.gnt) begin
                        state_d = ST_WAIT;
                        kill_d  = 1'b1;
                    end else begin
                        state_d = ST_ISSUE;
                    end
                end
                ST_WAIT: begin
                    if (imem.rvalid) begin
                        state_d = ST_ISSUE;
                        kill_d  = 1'b0;
                    end else begin
                        state_d = ST_WAIT;
                        kill_d  = 1'b1;
                    end
                end
                default: state_d = ST_ISSUE;
            endcase
        end
    end

    // Requests pause while a stale response from before reset is still owed.
    always_comb begin : outputs
        req_c     = ~rst & (state_q == ST_ISSUE) & ~kill_q;
        imem.req  = req_c;
        imem.addr = pcf_q;
    end

    assign InstrD   = instr_q;
    assign PCD      = pcd_q;
    assign PCPlus4D = pcp4_q;
    assign ValidD   = valid_q;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: a cycle-driven imem responder plus an IF/ID scoreboard.
module tb_fetch_sequencer;
    localparam logic [31:0] RESET_PC  = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        PCSrcE;
    logic [31:0] PCTargetE;
    logic        StallF;
    logic [31:0] InstrD, PCD, PCPlus4D;
    logic        ValidD;

    fetch_sequencer_if imem ();

    fetch_sequencer #(.RESET_PC(RESET_PC), .NOP_INSTR(NOP_INSTR)) dut (
        .clk       (clk),
        .rst       (rst),
        .PCSrcE    (PCSrcE),
        .PCTargetE (PCTargetE),
        .StallF    (StallF),
        .imem      (imem.master),
        .InstrD    (InstrD),
        .PCD       (PCD),
        .PCPlus4D  (PCPlus4D),
        .ValidD    (ValidD)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    exp_t        sb_q[$];
    logic [31:0] exp_pc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Hold gnt low for gdelay cycles, then accept; leaves the DUT waiting for rvalid.
    task automatic grant(input int gdelay);
        for (int i = 0; i < gdelay; i++) begin
            check("req_pending", 32'(imem.req), 32'd1);
            check("addr_stable", imem.addr, exp_pc);
            cyc();
        end
        imem.gnt = 1'b1;
        check("req", 32'(imem.req), 32'd1);
        check("addr", imem.addr, exp_pc);
        cyc();
        imem.gnt = 1'b0;
        check("req_wait", 32'(imem.req), 32'd0);
        check("valid_between", 32'(ValidD), 32'd0);
    endtask

    task automatic respond(input logic [31:0] data);
        imem.rvalid = 1'b1;
        imem.rdata  = data;
        cyc();
        imem.rvalid = 1'b0;
        imem.rdata  = 32'hx;
    endtask

    task automatic fetch(input logic [31:0] data, input int gdelay);
        sb_q.push_back('{instr: data, pc: exp_pc});
        grant(gdelay);
        respond(data);
        exp_pc = exp_pc + 32'd4;
    endtask

    // Every cycle with ValidD high must correspond to exactly one expected load.
    always @(negedge clk) begin
        if (ValidD === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("spurious_load", 32'(ValidD), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("InstrD", InstrD, e.instr);
                check("PCD", PCD, e.pc);
                check("PCPlus4D", PCPlus4D, e.pc + 32'd4);
            end
        end
    end

    initial begin
        rst = 1'b1; PCSrcE = 1'b0; PCTargetE = '0; StallF = 1'b0;
        imem.gnt = 1'b0; imem.rvalid = 1'b0; imem.rdata = '0;
        exp_pc = RESET_PC;

        // reset state
        cyc();
        check("rst_req", 32'(imem.req), 32'd0);
        check("rst_ValidD", 32'(ValidD), 32'd0);
        check("rst_InstrD", InstrD, NOP_INSTR);
        check("rst_PCD", PCD, 32'd0);
        check("rst_PCPlus4D", PCPlus4D, 32'd0);
        cyc();
        rst = 1'b0;
        #1;

        // zero-wait fetches
        fetch(32'h0010_0093, 0);
        fetch(32'h0020_0113, 0);
        fetch(32'h0030_0193, 0);
        fetch(32'h0040_0213, 0);

        // delayed grant at 0x10
        check("pc_0x10", exp_pc, 32'h10);
        fetch(32'h0050_0293, 3);

        // stall when the response arrives
        sb_q.push_back('{instr: 32'hDEAD_BEEF, pc: exp_pc});
        grant(0);
        StallF = 1'b1;
        respond(32'hDEAD_BEEF);
        check("stall_ValidD", 32'(ValidD), 32'd0);
        check("stall_InstrD", InstrD, NOP_INSTR);
        check("stall_PCD", PCD, 32'h10);
        check("hold_req", 32'(imem.req), 32'd0);
        cyc();
        check("hold_req2", 32'(imem.req), 32'd0);
        StallF = 1'b0;
        cyc();
        exp_pc = exp_pc + 32'd4;
        check("release_req", 32'(imem.req), 32'd1);
        check("release_addr", imem.addr, 32'h18);

        // redirect during WAIT, response later
        grant(0);
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0103;
        cyc();
        PCSrcE = 1'b0;
        check("redir_wait_req", 32'(imem.req), 32'd0);
        respond(32'hBAD0_0001);
        check("redir_wait_ValidD", 32'(ValidD), 32'd0);
        check("redir_wait_req2", 32'(imem.req), 32'd1);
        check("redir_wait_addr", imem.addr, 32'h100);
        exp_pc = 32'h100;

        // redirect with rvalid in the same cycle
        grant(0);
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0203;
        respond(32'hBAD0_0002);
        PCSrcE = 1'b0;
        check("redir_rv_ValidD", 32'(ValidD), 32'd0);
        check("redir_rv_addr", imem.addr, 32'h200);
        exp_pc = 32'h200;

        // redirect in ISSUE coincident with grant
        imem.gnt = 1'b1; PCSrcE = 1'b1; PCTargetE = 32'h0000_0300;
        cyc();
        imem.gnt = 1'b0; PCSrcE = 1'b0;
        check("redir_gnt_req", 32'(imem.req), 32'd0);
        respond(32'hBAD0_0003);
        check("redir_gnt_ValidD", 32'(ValidD), 32'd0);
        check("redir_gnt_addr", imem.addr, 32'h300);
        exp_pc = 32'h300;

        // redirect and stall together in HOLD
        grant(0);
        StallF = 1'b1;
        respond(32'hBAD0_0004);
        check("hold5_req", 32'(imem.req), 32'd0);
        PCSrcE = 1'b1; PCTargetE = 32'h0000_0400;
        cyc();
        PCSrcE = 1'b0; StallF = 1'b0;
        check("hold5_ValidD", 32'(ValidD), 32'd0);
        check("hold5_InstrD", InstrD, NOP_INSTR);
        check("hold5_req2", 32'(imem.req), 32'd1);
        check("hold5_addr", imem.addr, 32'h400);
        exp_pc = 32'h400;

        // redirect in ISSUE without grant, to the top of the address space
        PCSrcE = 1'b1; PCTargetE = 32'hFFFF_FFFF;
        cyc();
        PCSrcE = 1'b0;
        exp_pc = 32'hFFFF_FFFC;
        check("redir_issue_addr", imem.addr, exp_pc);
        fetch(32'h1111_1111, 0);
        check("wrap_pc", exp_pc, 32'h0);
        fetch(32'h2222_2222, 0);

        // reset while a response is outstanding
        grant(0);
        rst = 1'b1;
        #1;
        check("midrst_req", 32'(imem.req), 32'd0);
        cyc();
        rst = 1'b0;
        check("midrst_ValidD", 32'(ValidD), 32'd0);
        check("midrst_addr", imem.addr, RESET_PC);
        respond(32'hBAD0_0005);
        check("stale_ValidD", 32'(ValidD), 32'd0);
        check("stale_req", 32'(imem.req), 32'd1);
        check("stale_addr", imem.addr, RESET_PC);
        exp_pc = RESET_PC;
        fetch(32'h3333_3333, 0);

        cyc();
        check("sb_empty", 32'(sb_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
